// File: rtl/imem_fetch_ctrl_if.sv
// Signal bundle between imem_fetch_ctrl, the core fetch stage and the instruction ROM.
// The master modport is the fetch controller; the slave modport is the core/ROM side.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              flush_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic              inst_ready_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              mem_ce_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_i;

  modport master (
    input  flush_i,
    input  flush_pc_i,
    input  inst_ready_i,
    input  mem_data_i,
    output inst_valid_o,
    output inst_o,
    output inst_pc_o,
    output mem_ce_o,
    output mem_addr_o
  );

  modport slave (
    output flush_i,
    output flush_pc_i,
    output inst_ready_i,
    output mem_data_i,
    input  inst_valid_o,
    input  inst_o,
    input  inst_pc_o,
    input  mem_ce_o,
    input  mem_addr_o
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Prefetching instruction-fetch controller: one outstanding ROM request feeding a show-ahead FIFO.
// Optional macro IMEM_PERF_CNT_EN adds the fetch_cnt_o / flush_drop_o performance counters.
module imem_fetch_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                WAIT_CYCLES = 1,
  parameter int                DEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  imem_fetch_ctrl_if.master bus
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_drop_o
`endif
);

  localparam int                PTR_W       = $clog2(DEPTH);
  localparam int                CNT_W       = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [3:0]        WAIT_LIM    = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  state_e            r_state;
  state_e            w_stateNext;
  logic [ADDR_W-1:0] r_fetchPc;
  logic [ADDR_W-1:0] w_fetchPcNext;
  logic              r_ce;
  logic              w_ceNext;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addrNext;
  logic [3:0]        r_waitCnt;
  logic [3:0]        w_waitCntNext;

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_countNext;
  logic [ADDR_W-1:0] r_fifoPc   [DEPTH];
  logic [DATA_W-1:0] r_fifoData [DEPTH];

  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_space;
  logic [ADDR_W-1:0] w_pcInc;
  logic [ADDR_W-1:0] w_flushPc;
  logic              w_unused;

  // Flush masks both the pop and the capture, so a redirect never leaks stale data.
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && bus.inst_ready_i && !bus.flush_i;
  assign w_push      = (r_state == ST_WAIT) && (r_waitCnt == WAIT_LIM) && !bus.flush_i;
  assign w_countNext = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_space     = (w_countNext < DEPTH_C);
  assign w_pcInc     = r_fetchPc + PC_STEP;
  assign w_flushPc   = {bus.flush_pc_i[ADDR_W-1:2], 2'b00};
  assign w_unused    = ^bus.flush_pc_i[1:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_fetchPc <= RESET_PC_AL;
      r_ce      <= 1'b0;
      r_addr    <= '0;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_fetchPc <= w_fetchPcNext;
      r_ce      <= w_ceNext;
      r_addr    <= w_addrNext;
      r_waitCnt <= w_waitCntNext;
    end
  end

  // A new request is launched only when the slot it will fill is already guaranteed.
  always_comb begin
    w_stateNext   = r_state;
    w_fetchPcNext = r_fetchPc;
    w_ceNext      = r_ce;
    w_addrNext    = r_addr;
    w_waitCntNext = r_waitCnt;
    if (bus.flush_i) begin
      w_stateNext   = ST_IDLE;
      w_fetchPcNext = w_flushPc;
      w_ceNext      = 1'b0;
      w_waitCntNext = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_space) begin
            w_stateNext   = ST_WAIT;
            w_ceNext      = 1'b1;
            w_addrNext    = r_fetchPc;
            w_waitCntNext = '0;
          end
        end
        ST_WAIT: begin
          if (w_push) begin
            w_fetchPcNext = w_pcInc;
            w_waitCntNext = '0;
            if (w_space) begin
              w_addrNext = w_pcInc;
            end else begin
              w_ceNext    = 1'b0;
              w_stateNext = ST_IDLE;
            end
          end else begin
            w_waitCntNext = r_waitCnt + 4'd1;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_ceNext    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= w_countNext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifoPc[r_wrPtr]   <= r_fetchPc;
      r_fifoData[r_wrPtr] <= bus.mem_data_i;
    end
  end

  assign bus.inst_valid_o = w_valid;
  assign bus.inst_o       = w_valid ? r_fifoData[r_rdPtr] : '0;
  assign bus.inst_pc_o    = w_valid ? r_fifoPc[r_rdPtr] : '0;
  assign bus.mem_ce_o     = r_ce;
  assign bus.mem_addr_o   = r_addr;

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] r_fetchCnt;
  logic [31:0] r_flushDrop;
  logic [32:0] w_dropSum;

  // Entries lost to a flush are the queued words plus the request still in flight.
  assign w_dropSum = {1'b0, r_flushDrop} + 33'(r_count) + 33'(r_ce);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetchCnt  <= '0;
      r_flushDrop <= '0;
    end else begin
      if (w_pop && (r_fetchCnt != '1)) begin
        r_fetchCnt <= r_fetchCnt + 32'd1;
      end
      if (bus.flush_i) begin
        r_flushDrop <= w_dropSum[32] ? '1 : w_dropSum[31:0];
      end
    end
  end

  assign fetch_cnt_o  = r_fetchCnt;
  assign flush_drop_o = r_flushDrop;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: three configurations checked cycle by cycle
// against a queue-based transaction model of the fetch engine.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

  function automatic int waitOf(input int s);
    case (s)
      0:       return 0;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int depthOf(input int s);
    return (s == 0) ? 8 : 4;
  endfunction

  function automatic logic [31:0] resetPcOf(input int s);
    return (s == 1) ? 32'hFFFF_FFF8 : 32'h0000_0000;
  endfunction

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  logic        clk = 1'b0;
  logic [2:0]  rstN = 3'b000;
  logic        flush = 1'b0;
  logic [31:0] flushPc = '0;
  logic        ready = 1'b0;
  int          sel = 0;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    imem_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ifc ();
    logic [97:0] obsVec;
`ifdef IMEM_PERF_CNT_EN
    logic [31:0] fetchCnt;
    logic [31:0] flushDrop;
`endif

    assign ifc.flush_i      = flush;
    assign ifc.flush_pc_i   = flushPc;
    assign ifc.inst_ready_i = ready;
    assign ifc.mem_data_i   = romWord(ifc.mem_addr_o);
    assign obsVec = {ifc.inst_valid_o, ifc.inst_o, ifc.inst_pc_o, ifc.mem_ce_o, ifc.mem_addr_o};

    imem_fetch_ctrl #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .WAIT_CYCLES (waitOf(g)),
      .DEPTH       (depthOf(g)),
      .RESET_PC    (resetPcOf(g))
    ) dut (
      .clk_i        (clk),
      .rst_i        (rstN[g]),
      .bus          (ifc)
`ifdef IMEM_PERF_CNT_EN
      ,
      .fetch_cnt_o  (fetchCnt),
      .flush_drop_o (flushDrop)
`endif
    );
  end

  // Outputs of whichever instance is currently under test: valid, inst, pc, ce, addr.
  logic [97:0] obs;
  always_comb begin
    case (sel)
      0:       obs = gDut[0].obsVec;
      1:       obs = gDut[1].obsVec;
      default: obs = gDut[2].obsVec;
    endcase
  end

`ifdef IMEM_PERF_CNT_EN
  logic [63:0] obsPerf;
  always_comb begin
    case (sel)
      0:       obsPerf = {gDut[0].fetchCnt, gDut[0].flushDrop};
      1:       obsPerf = {gDut[1].fetchCnt, gDut[1].flushDrop};
      default: obsPerf = {gDut[2].fetchCnt, gDut[2].flushDrop};
    endcase
  end
`endif

  // Reference model: a queue of {pc, word}, the next fetch address, and a countdown
  // to the completion of the single outstanding ROM request.
  logic [63:0] mq[$];
  logic [31:0] mPc;
  bit          mBusy;
  int          mLeft;
  int          mW;
  int          mDepth;
  logic [31:0] mFetchCnt;
  logic [31:0] mDrop;

  task automatic modelReset(input int s);
    mq.delete();
    mPc       = resetPcOf(s);
    mBusy     = 1'b0;
    mLeft     = 0;
    mW        = waitOf(s);
    mDepth    = depthOf(s);
    mFetchCnt = '0;
    mDrop     = '0;
  endtask

  task automatic modelAdvance();
    logic   doPop;
    longint sum;
    doPop = (mq.size() != 0) && ready && !flush;
    if (flush) begin
      sum = 64'(mDrop);
      sum += 64'(mq.size());
      if (mBusy) sum += 1;
      if (sum > 64'hFFFF_FFFF) mDrop = '1;
      else mDrop = sum[31:0];
      mq.delete();
      mBusy = 1'b0;
      mLeft = 0;
      mPc   = {flushPc[31:2], 2'b00};
    end else begin
      if (doPop) begin
        void'(mq.pop_front());
        if (mFetchCnt != '1) mFetchCnt++;
      end
      if (mBusy) begin
        if (mLeft == 0) begin
          mq.push_back({mPc, romWord(mPc)});
          mPc   = mPc + 32'd4;
          mBusy = 1'b0;
        end else begin
          mLeft--;
        end
      end
      if (!mBusy && (mq.size() < mDepth)) begin
        mBusy = 1'b1;
        mLeft = mW;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic compareAll();
    logic [63:0] head;
    head = '0;
    if (mq.size() != 0) head = mq[0];
    checkOutput("inst_valid", 64'(obs[97]), 64'(mq.size() != 0));
    checkOutput("inst_o", 64'(obs[96:65]), 64'(head[31:0]));
    checkOutput("inst_pc_o", 64'(obs[64:33]), 64'(head[63:32]));
    checkOutput("mem_ce_o", 64'(obs[32]), 64'(mBusy));
    if (mBusy) checkOutput("mem_addr_o", 64'(obs[31:0]), 64'(mPc));
`ifdef IMEM_PERF_CNT_EN
    checkOutput("fetch_cnt_o", 64'(obsPerf[63:32]), 64'(mFetchCnt));
    checkOutput("flush_drop_o", 64'(obsPerf[31:0]), 64'(mDrop));
`endif
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 64'(obs[97]), 64'd0);
    checkOutput({tag, "_inst"}, 64'(obs[96:65]), 64'd0);
    checkOutput({tag, "_pc"}, 64'(obs[64:33]), 64'd0);
    checkOutput({tag, "_ce"}, 64'(obs[32]), 64'd0);
    checkOutput({tag, "_addr"}, 64'(obs[31:0]), 64'd0);
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model, check at the next falling edge.
  task automatic applyStimulus(input logic rdy, input logic fl, input logic [31:0] fpc);
    ready   = rdy;
    flush   = fl;
    flushPc = fpc;
    modelAdvance();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyRandom(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
    end
  endtask

  task automatic startDut(input int s);
    rstN    = '0;
    sel     = s;
    ready   = 1'b0;
    flush   = 1'b0;
    flushPc = '0;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    modelReset(s);
    rstN[s] = 1'b1;
    #1;
    compareAll();
  endtask

  bit found;

  initial begin
    $display("[TB] imem_fetch_ctrl bench start");
    @(negedge clk);

    // Zero wait states: one word per cycle once the pipeline fills.
    startDut(0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, '0);
    applyRandom(200);

    // Two wait states starting just below the address wrap point.
    startDut(1);
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b0, '0);
    applyRandom(200);

    // One wait state: fill with the core stalled, then drain.
    startDut(2);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("fill_ce_low", 64'(obs[32]), 64'd0);
    checkOutput("fill_valid", 64'(obs[97]), 64'd1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, '0);

    // Redirect while a request is in flight, with an unaligned target.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mBusy) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b1, 1'b0, '0);
    end
    checkOutput("wait_busy", 64'(found), 64'd1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0103);
    checkOutput("flush_empty", 64'(obs[97]), 64'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0);

    // Redirect landing on a capture cycle while the head is being accepted.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mBusy && (mLeft == 0) && (mq.size() != 0)) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, '0);
    end
    checkOutput("wait_capture", 64'(found), 64'd1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);

    // Flush held for several cycles: the last target wins.
    applyStimulus(1'b1, 1'b1, 32'h0000_0300);
    applyStimulus(1'b0, 1'b1, 32'h0000_0404);
    applyStimulus(1'b1, 1'b1, 32'h0000_0508);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0);
    applyRandom(300);

    // Reset asserted mid-request must clear the outputs before the next clock edge.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mBusy) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, '0);
    end
    checkOutput("wait_busy_rst", 64'(found), 64'd1);
    #2;
    rstN[2] = 1'b0;
    #1;
    checkAllZero("async_rst");
    modelReset(2);
    @(posedge clk);
    @(negedge clk);
    compareAll();
    rstN[2] = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Parametrised instruction-fetch controller between the RV32 core fetch stage and the instruction ROM.
- Replaces the direct core-to-ROM ce/addr/inst hookup with a prefetching engine. It supports a configurable ROM wait-state count and a DEPTH-entry prefetch FIFO.
- Core side: a valid/ready instruction stream with a redirect (flush) input for branches and jumps.

Parameters:
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction word width.
- WAIT_CYCLES, 1, ROM latency in cycles (legal 0..15); data is sampled WAIT_CYCLES cycles after the request starts.
- DEPTH, 4, prefetch FIFO entries (power of 2, minimum 2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  redirect request from the core.
- flush_pc_i  in  ADDR_W  redirect target.
- inst_ready_i  in  1  core accepts the head instruction.
- inst_valid_o  out  1  head instruction valid.
- inst_o  out  DATA_W  head instruction word.
- inst_pc_o  out  ADDR_W  PC of the head instruction.
- mem_ce_o  out  1  ROM chip enable.
- mem_addr_o  out  ADDR_W  ROM word address.
- mem_data_i  in  DATA_W  ROM read data.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty, wait counter=0, FSM=IDLE.
  - Outputs: mem_ce_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
- FIFO:
  - Show-ahead. inst_o and inst_pc_o present the head entry; both are 0 when empty.
  - inst_valid_o = (count!=0).
  - Pop occurs when inst_valid_o && inst_ready_i && !flush_i.
  - Pointers wrap modulo DEPTH.
  - count is ceil(log2(DEPTH+1)) bits wide.
- FSM states are IDLE and WAIT.
  - IDLE: if !flush_i and (count - pop) < DEPTH, start a request.
    - mem_ce_o=1 and mem_addr_o=fetch_pc, registered, effective from the next cycle.
    - If WAIT_CYCLES=0: stay in request mode. Data is captured in the same cycle mem_ce_o is high, giving throughput of 1 word/cycle.
    - If WAIT_CYCLES>0: go to WAIT.
  - WAIT: mem_ce_o and mem_addr_o are held stable and the counter increments each cycle.
    - When counter==WAIT_CYCLES, capture mem_data_i: push {fetch_pc, data} and set fetch_pc += 4.
    - If space remains (count after this cycle's push/pop < DEPTH), issue the next request immediately. Otherwise drop mem_ce_o and return to IDLE.
    - Throughput is 1 word per WAIT_CYCLES+1 cycles.
- Space rule:
  - At most one request is outstanding.
  - A request starts only when a slot is free, so a capture always has space.
  - Push and pop in the same cycle when full are both legal.
- Flush_i has highest priority over push, pop and issue in the same cycle:
  - The FIFO is cleared, so inst_valid_o=0 next cycle.
  - The in-flight request is aborted: data is discarded even if capture coincides.
  - mem_ce_o=0 next cycle and the counter is cleared.
  - fetch_pc <= {flush_pc_i[ADDR_W-1:2], 2'b00}.
  - Fetch resumes the cycle after the flush, provided flush_i has been released.
  - flush_i held high keeps the block idle and empty; the last flush_pc_i wins.
- fetch_pc wraps 0xFFFF_FFFC -> 0x0000_0000 with no flag.
- Reset asserted mid-request: everything clears immediately; no partial push.
- mem_addr_o is always word-aligned (bits[1:0]=0).
- First inst_valid_o after reset deassertion: cycle 1+WAIT_CYCLES+1, counted from the first rising edge with rst_i=1.

Optional Feature:
- Macro: IMEM_PERF_CNT_EN.
- When defined:
  - Adds output fetch_cnt_o, 32 bits: the number of instructions popped by the core. It is cleared on reset, saturates at 0xFFFF_FFFF, and is not cleared by flush.
  - Adds output flush_drop_o, 32 bits: cumulative FIFO entries plus in-flight requests discarded by flushes. It saturates.
- When undefined: neither port nor its counters exist; behaviour is otherwise identical.

Test Plan:
- Reset, WAIT_CYCLES=0, ROM word[i]=i, inst_ready_i=1 -> inst_pc_o sequence 0,4,8,... and inst_o 0,1,2,... on consecutive cycles after the first valid; no gaps.
- WAIT_CYCLES=2, inst_ready_i=1 -> mem_addr_o held 3 cycles per word; a new valid word every 3 cycles; mem_ce_o continuously high.
- inst_ready_i=0 for 20 cycles, DEPTH=4 -> exactly 4 entries (PCs 0,4,8,C); mem_ce_o=0 afterwards. Then ready=1 -> the 4 words drain in order, and fetch resumes at 0x10.
- Mid-WAIT flush_i with flush_pc_i=0x0000_0103 -> FIFO empty next cycle, in-flight data never appears, next mem_addr_o=0x0000_0100, next inst_pc_o=0x100.
- Flush coinciding with a capture cycle and a pop -> no push, no pop counted, valid=0 next cycle. Perf variant: fetch_cnt_o unchanged and flush_drop_o += (prior count+1).
- RESET_PC=0xFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert rst_i=0 mid-WAIT -> all outputs 0 asynchronously, before the next clock edge.
